alu_issue: RTL
==============

Name: alu_issue

Overview:
- ID/EX issue stage sitting directly upstream of the ALU.
- Accepts one RV32I instruction per cycle along with PC and register-file read data, and decodes OP, OP-IMM, LUI and AUIPC.
- Registers the ALU operands, ALU control fields and writeback info behind a two-entry skid buffer with valid/ready handshakes on both sides.
- Outputs drive the ALU's i_op_a/i_op_b/i_sub/i_bool_op/i_op_sel/i_shift_dir ports directly.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept; registered
i_insn  in  32  raw instruction
i_pc  in  32  instruction PC
i_rs1_data  in  32  rs1 read data
i_rs2_data  in  32  rs2 read data
i_flush  in  1  discard all held entries
o_valid  out  1  downstream entry valid
i_ready  in  1  downstream accepts
o_op_a  out  32  ALU operand A
o_op_b  out  32  ALU operand B
o_sub  out  1  subtract / arithmetic-shift select
o_bool_op  out  2  boolean select; bit0 = unsigned compare for SLT
o_op_sel  out  4  one-hot: 0001 add, 0010 slt, 0100 bool, 1000 shift
o_shift_dir  out  1  0 left, 1 right
o_rd  out  5  destination register
o_rd_we  out  1  writeback enable
o_illegal  out  1  instruction not decodable by this stage

Behaviour:
- Reset (async on i_rst_n low):
  - o_valid=0, o_ready=1, skid empty.
  - All data outputs 0.
- Handshakes:
  - Accept when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - An entry is held stable while o_valid && !i_ready.
- Skid buffer (output register plus one skid register):
  - Accepted entry goes to the output register if it is empty or being transferred this cycle; otherwise it goes to skid.
  - On transfer with skid full, skid moves to the output register.
  - o_ready = !skid_full, registered.
  - Full throughput; latency 1 cycle from accept to o_valid.
- Flush:
  - i_flush clears both entries; o_valid=0 and o_ready=1 next cycle.
  - A same-cycle accept is dropped.
  - Flush has priority over accept and transfer.
- Decode, by funct3 (OP and OP-IMM share it):
  - 000 ADD/ADDI: sel 0001; o_sub = OP && funct7[5]. SUB is legal only on OP.
  - 001 SLL: sel 1000, dir 0, sub 0.
  - 010 SLT: sel 0010, sub 1, bool 00.
  - 011 SLTU: sel 0010, sub 1, bool 01.
  - 100 XOR: sel 0100, bool 00.
  - 101 SRL/SRA: sel 1000, dir 1, sub = funct7[5].
  - 110 OR: sel 0100, bool 10.
  - 111 AND: sel 0100, bool 11.
- Operands:
  - o_op_a = rs1_data.
  - o_op_b for OP = rs2_data.
  - o_op_b for OP-IMM = sign-extended I-immediate.
  - o_op_b for shift-immediates = zero-extended shamt (insn[24:20]).
- LUI: op_a=0, op_b={insn[31:12],12'b0}, add.
- AUIPC: op_a=i_pc, op_b=U-immediate, add.
- funct7 legality:
  - Shifts and OP register forms require funct7 0000000.
  - funct7 0100000 is legal only for SUB/SRA/SRAI.
  - Anything else is illegal.
- Illegal entries:
  - o_illegal=1, o_rd_we=0; all control fields and operands 0.
  - Still passed downstream as a normal entry.
- o_rd = insn[11:7]. o_rd_we = legal && rd!=0.
- Unused control fields are always driven 0, never X.

Decomposition:
- Package risky_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC);
  - op_sel one-hot constants;
  - bool_op encodings;
  - packed struct alu_ctrl_t {sub, bool_op, op_sel, shift_dir}.
- Sub-module alu_decode: purely combinational; maps insn/pc/rs data to the operand pair, alu_ctrl_t, rd, rd_we and illegal.
- alu_issue holds only the skid buffer and handshake logic.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293), rs1=0 -> next cycle o_valid=1, op_a=0, op_b=0xFFFFFFFF, sel 0001, sub 0, rd 5, we 1.
- SUB x3,x1,x2 (0x402081B3), rs1=1234, rs2=5678 -> op_a=1234, op_b=5678, sel 0001, sub 1, rd 3.
- SRAI x7,x6,8 (0x40835393), rs1=0xF000FFFF -> op_b=8, sel 1000, dir 1, sub 1; on the ALU gives 0xFFF000FF.
- LUI x1,0x12345 (0x123450B7) -> op_a=0, op_b=0x12345000; then insn 0x00000000 -> o_illegal=1, rd_we=0, controls 0.
- i_ready=0 with 3 back-to-back valid insns:
  - 2 accepted; o_ready=0 the cycle after the second.
  - After releasing i_ready, outputs appear in order with no loss or duplication; o_ready returns to 1.
- Skid full, then i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1, no entry emitted; async reset mid-stream -> same state immediately.

Source files
------------

// File: rtl/risky_pkg.sv
// -----------------------------------------------------------------------------
// risky_pkg
// Shared definitions for the ALU issue stage:
//   - RV32I opcode and funct7 constants for the instruction classes decoded here
//   - one-hot ALU op_sel constants and bool_op encodings
//   - alu_ctrl_t: the control bundle driven into the ALU
//   - issue_t:    one complete skid-buffer entry (operands + control + writeback)
// -----------------------------------------------------------------------------
package risky_pkg;

  localparam int XLEN = 32;

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values that may appear on legal OP / shift-immediate encodings
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One-hot ALU result select
  localparam logic [3:0] SEL_ADD   = 4'b0001;
  localparam logic [3:0] SEL_SLT   = 4'b0010;
  localparam logic [3:0] SEL_BOOL  = 4'b0100;
  localparam logic [3:0] SEL_SHIFT = 4'b1000;

  // bool_op encodings; for SLT/SLTU bit0 selects the unsigned compare
  localparam logic [1:0] BOOL_XOR  = 2'b00;
  localparam logic [1:0] BOOL_SLT  = 2'b00;
  localparam logic [1:0] BOOL_SLTU = 2'b01;
  localparam logic [1:0] BOOL_OR   = 2'b10;
  localparam logic [1:0] BOOL_AND  = 2'b11;

  // funct3 is shared between OP and OP-IMM
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef struct packed {
    logic       sub;
    logic [1:0] bool_op;
    logic [3:0] op_sel;
    logic       shift_dir;
  } alu_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    alu_ctrl_t       ctrl;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
// Upstream and downstream handshake/bus signals of the ALU issue stage.
//   upstream   : i_valid / o_ready, i_insn, i_pc, i_rs1_data, i_rs2_data, i_flush
//   downstream : o_valid / i_ready, o_op_a, o_op_b, o_sub, o_bool_op, o_op_sel,
//                o_shift_dir, o_rd, o_rd_we, o_illegal
// Modports:
//   slave  - the issue stage itself
//   master - the environment around it (decode/regfile upstream, ALU downstream)
// -----------------------------------------------------------------------------
interface alu_issue_if;
  import risky_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_insn;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic            i_flush;

  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_op_a;
  logic [XLEN-1:0] o_op_b;
  logic            o_sub;
  logic [1:0]      o_bool_op;
  logic [3:0]      o_op_sel;
  logic            o_shift_dir;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_insn, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
    output o_ready, o_valid, o_op_a, o_op_b, o_sub, o_bool_op, o_op_sel,
           o_shift_dir, o_rd, o_rd_we, o_illegal
  );

  modport master (
    output i_valid, i_insn, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
    input  o_ready, o_valid, o_op_a, o_op_b, o_sub, o_bool_op, o_op_sel,
           o_shift_dir, o_rd, o_rd_we, o_illegal
  );

endinterface

// File: rtl/alu_decode.sv
// -----------------------------------------------------------------------------
// alu_decode
// Purely combinational RV32I decode for OP, OP-IMM, LUI and AUIPC.
// Ports:
//   i_insn, i_pc, i_rs1_data, i_rs2_data : instruction and its source data
//   o_op_a, o_op_b : ALU operands (zero for illegal instructions)
//   o_ctrl         : ALU control bundle (zero for illegal instructions)
//   o_rd, o_rd_we  : writeback destination / enable (no write to x0)
//   o_illegal      : instruction is not handled by this stage
// -----------------------------------------------------------------------------
module alu_decode
  import risky_pkg::*;
(
  input  logic [31:0]     i_insn,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output alu_ctrl_t       o_ctrl,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_illegal
);

  logic [6:0]      w_opcode;
  logic [6:0]      w_funct7;
  funct3_e         w_funct3;
  logic            w_is_op;
  logic            w_is_shift;
  logic            w_legal;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  alu_ctrl_t       w_ctrl;
  logic            w_unused_rs1_field;

  assign w_opcode   = i_insn[6:0];
  assign w_funct7   = i_insn[31:25];
  assign w_funct3   = funct3_e'(i_insn[14:12]);
  assign w_is_op    = (w_opcode == OPC_OP);
  assign w_is_shift = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);
  assign w_imm_i    = {{20{i_insn[31]}}, i_insn[31:20]};
  assign w_imm_u    = {i_insn[31:12], 12'b0};
  assign w_shamt    = {27'b0, i_insn[24:20]};

  // The rs1 index was already used by the register file read upstream.
  assign w_unused_rs1_field = ^i_insn[19:15];

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_legal = 1'b0;
    w_op_a  = '0;
    w_op_b  = '0;
    w_ctrl  = '0;

    unique case (w_opcode)
      OPC_LUI: begin
        w_legal       = 1'b1;
        w_op_b        = w_imm_u;
        w_ctrl.op_sel = SEL_ADD;
      end

      OPC_AUIPC: begin
        w_legal       = 1'b1;
        w_op_a        = i_pc;
        w_op_b        = w_imm_u;
        w_ctrl.op_sel = SEL_ADD;
      end

      OPC_OP, OPC_OP_IMM: begin
        // funct7 only constrains register forms and shift-immediates; the
        // alternate encoding exists only for SUB (register form) and SRA/SRAI.
        if (!w_is_op && !w_is_shift)
          w_legal = 1'b1;
        else if (w_funct7 == F7_ZERO)
          w_legal = 1'b1;
        else if (w_funct7 == F7_ALT)
          w_legal = (w_funct3 == F3_SR) || (w_is_op && (w_funct3 == F3_ADD));
        else
          w_legal = 1'b0;

        w_op_a = i_rs1_data;
        if (w_is_op)
          w_op_b = i_rs2_data;
        else if (w_is_shift)
          w_op_b = w_shamt;
        else
          w_op_b = w_imm_i;

        unique case (w_funct3)
          F3_ADD: begin
            w_ctrl.op_sel = SEL_ADD;
            w_ctrl.sub    = w_is_op && w_funct7[5];
          end
          F3_SLL: begin
            w_ctrl.op_sel    = SEL_SHIFT;
            w_ctrl.shift_dir = 1'b0;
          end
          F3_SLT: begin
            w_ctrl.op_sel  = SEL_SLT;
            w_ctrl.sub     = 1'b1;
            w_ctrl.bool_op = BOOL_SLT;
          end
          F3_SLTU: begin
            w_ctrl.op_sel  = SEL_SLT;
            w_ctrl.sub     = 1'b1;
            w_ctrl.bool_op = BOOL_SLTU;
          end
          F3_XOR: begin
            w_ctrl.op_sel  = SEL_BOOL;
            w_ctrl.bool_op = BOOL_XOR;
          end
          F3_SR: begin
            w_ctrl.op_sel    = SEL_SHIFT;
            w_ctrl.shift_dir = 1'b1;
            w_ctrl.sub       = w_funct7[5];
          end
          F3_OR: begin
            w_ctrl.op_sel  = SEL_BOOL;
            w_ctrl.bool_op = BOOL_OR;
          end
          F3_AND: begin
            w_ctrl.op_sel  = SEL_BOOL;
            w_ctrl.bool_op = BOOL_AND;
          end
          default: w_ctrl = '0;
        endcase
      end

      default: w_legal = 1'b0;
    endcase

    // Illegal entries still flow downstream, but must not perturb the ALU.
    if (!w_legal) begin
      w_op_a = '0;
      w_op_b = '0;
      w_ctrl = '0;
    end
  end

  assign o_op_a    = w_op_a;
  assign o_op_b    = w_op_b;
  assign o_ctrl    = w_ctrl;
  assign o_rd      = i_insn[11:7];
  assign o_rd_we   = w_legal && (i_insn[11:7] != 5'd0);
  assign o_illegal = !w_legal;

endmodule

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// ID/EX issue stage feeding the ALU. Decodes one instruction per cycle and
// registers the result behind a two-entry skid buffer (output register plus
// one skid register) with valid/ready on both sides.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   io_bus         : alu_issue_if.slave - upstream accept (i_valid/o_ready,
//                    insn, pc, rs data, i_flush) and downstream ALU operands,
//                    control and writeback info (o_valid/i_ready)
// o_ready is registered and equals "skid register empty"; a flush empties
// both entries and wins over a same-cycle accept or transfer.
// -----------------------------------------------------------------------------
module alu_issue
  import risky_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  alu_issue_if.slave  io_bus
);

  issue_t w_dec;
  logic   w_accept;
  logic   w_xfer;
  logic   w_out_free;
  logic   w_out_valid_nxt;
  logic   w_skid_valid_nxt;
  logic   w_load_out_from_skid;
  logic   w_load_out_from_in;
  logic   w_load_skid;

  issue_t r_out;
  issue_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;
  logic   r_ready;

  alu_decode u_decode (
    .i_insn     (io_bus.i_insn),
    .i_pc       (io_bus.i_pc),
    .i_rs1_data (io_bus.i_rs1_data),
    .i_rs2_data (io_bus.i_rs2_data),
    .o_op_a     (w_dec.op_a),
    .o_op_b     (w_dec.op_b),
    .o_ctrl     (w_dec.ctrl),
    .o_rd       (w_dec.rd),
    .o_rd_we    (w_dec.rd_we),
    .o_illegal  (w_dec.illegal)
  );

  assign w_accept   = io_bus.i_valid && r_ready;
  assign w_xfer     = r_out_valid && io_bus.i_ready;
  assign w_out_free = !r_out_valid || w_xfer;

  // Skid buffer next-state. An accept is only possible with the skid empty,
  // so the skid never has to take a new entry and drain in the same cycle.
  always_comb begin
    w_out_valid_nxt      = r_out_valid;
    w_skid_valid_nxt     = r_skid_valid;
    w_load_out_from_skid = 1'b0;
    w_load_out_from_in   = 1'b0;
    w_load_skid          = 1'b0;

    if (io_bus.i_flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        w_load_out_from_skid = 1'b1;
        w_out_valid_nxt      = 1'b1;
        w_skid_valid_nxt     = 1'b0;
      end else if (w_accept) begin
        w_load_out_from_in = 1'b1;
        w_out_valid_nxt    = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_load_skid      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_out        <= '{op_a: {XLEN{1'b0}}, op_b: {XLEN{1'b0}}, default: '0};
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_ready      <= !w_skid_valid_nxt;
      if (w_load_out_from_skid)
        r_out <= r_skid;
      else if (w_load_out_from_in)
        r_out <= w_dec;
    end
  end

  // NOTE: the skid payload is qualified by r_skid_valid and never reaches the
  // outputs directly, so it is deliberately left without a reset.
  always_ff @(posedge i_clk) begin
    if (w_load_skid)
      r_skid <= w_dec;
  end

  assign io_bus.o_ready     = r_ready;
  assign io_bus.o_valid     = r_out_valid;
  assign io_bus.o_op_a      = r_out.op_a;
  assign io_bus.o_op_b      = r_out.op_b;
  assign io_bus.o_sub       = r_out.ctrl.sub;
  assign io_bus.o_bool_op   = r_out.ctrl.bool_op;
  assign io_bus.o_op_sel    = r_out.ctrl.op_sel;
  assign io_bus.o_shift_dir = r_out.ctrl.shift_dir;
  assign io_bus.o_rd        = r_out.rd;
  assign io_bus.o_rd_we     = r_out.rd_we;
  assign io_bus.o_illegal   = r_out.illegal;

endmodule
